// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: MEM stage of the 5-stage RISC-V pipeline.
// Issues data memory requests, aligns load data and registers results toward WB.
module riscv_mem_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] alu_out_i,
    input  logic [WORD_SIZE-1:0] store_data_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    input  logic [4:0]           rd_i,
    input  logic                 reg_write_i,
    output logic                 stall_o,
    output logic                 data_req_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [WORD_SIZE-1:0] data_addr_o,
    output logic [WORD_SIZE-1:0] data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [WORD_SIZE-1:0] data_rdata_i,
    output logic                 wb_valid_o,
    output logic [WORD_SIZE-1:0] wb_data_o,
    output logic [4:0]           wb_rd_o,
    output logic                 wb_reg_write_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [3:0]           be_q, be_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [4:0]           rd_q, rd_d;
    logic                 rw_q, rw_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic                 wb_rw_q, wb_rw_d;
    logic                 err_q, err_d;

    logic                 is_mem;
    logic                 size_ok;
    logic                 acc_err;
    logic [1:0]           off;
    logic [3:0]           be_dec;
    logic [WORD_SIZE-1:0] wdata_dec;
    logic [WORD_SIZE-1:0] ld_shift;
    logic [WORD_SIZE-1:0] ld_data;

    // Decode size, alignment, byte enables and replicated store data
    always_comb begin
        off       = alu_out_i[1:0];
        is_mem    = mem_read_i | mem_write_i;
        size_ok   = 1'b0;
        be_dec    = 4'b0000;
        wdata_dec = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                size_ok   = 1'b1;
                be_dec    = 4'b0001 << off;
                wdata_dec = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                size_ok   = ~off[0];
                be_dec    = 4'b0011 << off;
                wdata_dec = {2{store_data_i[15:0]}};
            end
            2'b10: begin
                size_ok = (off == 2'b00);
                be_dec  = 4'b1111;
            end
            default: size_ok = 1'b0;
        endcase
        acc_err = (mem_read_i & mem_write_i)
                | ~size_ok
                | (mem_write_i & funct3_i[2])
                | (mem_read_i & funct3_i[2] & funct3_i[1]);
    end

    // Select the addressed byte/halfword and extend it
    always_comb begin
        ld_shift = data_rdata_i >> {off_q, 3'b000};
        ld_data  = data_rdata_i;
        case (funct3_q)
            3'b000:  ld_data = {{(WORD_SIZE-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(WORD_SIZE-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(WORD_SIZE-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(WORD_SIZE-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = data_rdata_i;
        endcase
    end

    // Next-state and registered-output logic of the request FSM
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    wb_rd_d = rd_i;
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_out_i;
                        wb_rw_d    = reg_write_i;
                    end else if (acc_err) begin
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d  = REQ;
                        req_d    = 1'b1;
                        we_d     = mem_write_i;
                        be_d     = be_dec;
                        addr_d   = {alu_out_i[WORD_SIZE-1:2], 2'b00};
                        wdata_d  = wdata_dec;
                        funct3_d = funct3_i;
                        off_d    = off;
                        rd_d     = rd_i;
                        rw_d     = reg_write_i;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_data;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            wb_rw_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            err_q      <= err_d;
        end
    end

    assign stall_o        = (state_q != IDLE);
    assign data_req_o     = req_q;
    assign data_we_o      = we_q;
    assign data_be_o      = be_q;
    assign data_addr_o    = addr_q;
    assign data_wdata_o   = wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_rw_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// tb_riscv_mem_stage: directed bench for the MEM stage.
// A memory responder and a reference model check outputs every cycle.
module tb_riscv_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i;
    logic [31:0] alu_out_i;
    logic [31:0] store_data_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic        stall_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_reg_write_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    riscv_mem_stage #(.WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .alu_out_i(alu_out_i), .store_data_i(store_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .stall_o(stall_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .wb_reg_write_o(wb_reg_write_o), .err_o(err_o)
    );

    typedef struct {
        bit          mr;
        bit          mw;
        bit [2:0]    f3;
        logic [31:0] a;
        logic [31:0] sd;
        bit [4:0]    rd;
        bit          rw;
        int          g;
        int          r;
        bit          xerr;
        bit [3:0]    xbe;
        bit          has_lit;
        logic [31:0] lit;
    } vec_t;

    typedef struct {
        int          cyc;
        bit          err;
        bit          rw;
        bit          cmp_data;
        logic [31:0] data;
        bit [4:0]    rd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit          req_exp = 0;
    int          req_start = 0;
    int          gcnt = 0;
    int          rdly = 1;
    logic [31:0] x_addr, x_wdata;
    bit [3:0]    x_be;
    bit          x_we;
    bit          pend_rv = 0;
    int          rvcnt = 0;
    logic [31:0] raddr;
    int          st_start = 0;
    int          st_end = 0;
    bit          run = 0;
    bit          ereq;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_err(bit mr, bit mw, bit [2:0] f3, logic [31:0] a);
        int f, nb;
        f = int'(f3);
        if (mr && mw) return 1'b1;
        if (mw && f > 2) return 1'b1;
        if (mr && !(f inside {0, 1, 2, 4, 5})) return 1'b1;
        nb = 1 << (f % 4);
        if (a % nb != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [3:0] m_be(bit [2:0] f3, logic [31:0] a);
        int nb;
        nb = 1 << (int'(f3) % 4);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(bit [2:0] f3, logic [31:0] sd);
        int nb;
        nb = 1 << (int'(f3) % 4);
        if (nb == 1) return {24'h0, sd[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'h0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(bit [2:0] f3, logic [31:0] a, logic [31:0] w);
        int nb;
        logic [31:0] v, mask;
        nb = 1 << (int'(f3) % 4);
        if (nb == 4) return w;
        v = w >> (8 * (a % 4));
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = v & mask;
        if (f3 < 3'd4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
        return old;
    endfunction

    function automatic vec_t mk(bit mr, bit mw, bit [2:0] f3, logic [31:0] a,
                                logic [31:0] sd, bit [4:0] rd, bit rw, int g, int r,
                                bit xerr, bit [3:0] xbe, bit has_lit, logic [31:0] lit);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.rw = rw;
        v.g = g; v.r = r; v.xerr = xerr; v.xbe = xbe; v.has_lit = has_lit; v.lit = lit;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int   n;
        exp_t e;
        bit   er;
        @(negedge clk_i);
        valid_i      = 1'b1;
        alu_out_i    = v.a;
        store_data_i = v.sd;
        mem_read_i   = v.mr;
        mem_write_i  = v.mw;
        funct3_i     = v.f3;
        rd_i         = v.rd;
        reg_write_i  = v.rw;
        n = 0;
        while (stall_o !== 1'b0) begin
            @(negedge clk_i);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout got stall_o %b want 0 within 100 cycles", stall_o);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "stall timeout");
            end
        end
        er = m_err(v.mr, v.mw, v.f3, v.a);
        chk("model_err", 32'(er), 32'(v.xerr));
        e.cyc = cyc + 1; e.err = er; e.rw = 1'b0; e.cmp_data = 1'b0;
        e.data = 32'h0; e.rd = v.rd;
        if (!v.mr && !v.mw) begin
            e.rw = v.rw; e.cmp_data = 1'b1; e.data = v.a;
        end else if (!er) begin
            x_addr  = v.a & ~32'h3;
            x_be    = m_be(v.f3, v.a);
            x_we    = v.mw;
            x_wdata = m_wdata(v.f3, v.sd);
            chk("model_be", 32'(x_be), 32'(v.xbe));
            req_exp = 1'b1; req_start = cyc; gcnt = v.g; rdly = v.r;
            if (v.mw) begin
                e.cyc = cyc + 2 + v.g;
                ref_mem[v.a[11:2]] = merge(ref_mem[v.a[11:2]], x_wdata, x_be);
            end else begin
                e.cyc = cyc + 2 + v.g + v.r;
                e.rw = v.rw; e.cmp_data = 1'b1;
                e.data = m_load(v.f3, v.a, ref_mem[v.a[11:2]]);
            end
            st_start = cyc; st_end = e.cyc;
        end
        if (v.has_lit) chk("model_data", e.data, v.lit);
        q.push_back(e);
        @(posedge clk_i);
    endtask

    task automatic idle();
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b0;
        q.delete(); req_exp = 1'b0; st_end = cyc + 1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_wb_rw", 32'(wb_reg_write_o), 32'h0);
        chk("rst_req", 32'(data_req_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
    endtask

    // Memory responder plus per-cycle comparison against the model
    initial begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            #1;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
            if (run) begin
                if (pend_rv) begin
                    rvcnt--;
                    if (rvcnt == 0) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = ram[raddr[11:2]];
                        pend_rv       = 1'b0;
                    end
                end
                ereq = req_exp && (cyc > req_start);
                chk("data_req_o", 32'(data_req_o), 32'(ereq));
                if (ereq && data_req_o) begin
                    chk("data_addr_o", data_addr_o, x_addr);
                    chk("data_we_o", 32'(data_we_o), 32'(x_we));
                    chk("data_be_o", 32'(data_be_o), 32'(x_be));
                    if (x_we) chk("data_wdata_o", data_wdata_o, x_wdata);
                    if (gcnt == 0) begin
                        data_gnt_i = 1'b1;
                        req_exp = 1'b0;
                        if (data_we_o)
                            ram[data_addr_o[11:2]] = merge(ram[data_addr_o[11:2]], data_wdata_o, data_be_o);
                        else begin
                            pend_rv = 1'b1; rvcnt = rdly; raddr = data_addr_o;
                        end
                    end else gcnt--;
                end
                chk("stall_o", 32'(stall_o), 32'(cyc > st_start && cyc < st_end));
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    chk("wb_valid_o", 32'(wb_valid_o), 32'h1);
                    chk("err_o", 32'(err_o), 32'(q[0].err));
                    chk("wb_reg_write_o", 32'(wb_reg_write_o), 32'(q[0].rw));
                    if (q[0].cmp_data) begin
                        chk("wb_data_o", wb_data_o, q[0].data);
                        chk("wb_rd_o", 32'(wb_rd_o), 32'(q[0].rd));
                    end
                    void'(q.pop_front());
                end else begin
                    chk("wb_valid_o_idle", 32'(wb_valid_o), 32'h0);
                    chk("err_o_idle", 32'(err_o), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        valid_i = 1'b0; alu_out_i = 32'h0; store_data_i = 32'h0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
        rd_i = 5'd0; reg_write_i = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        ram[10'h080] = 32'h0080_0000; ref_mem[10'h080] = 32'h0080_0000;
        ram[10'h100] = 32'hDEAD_BEEF; ref_mem[10'h100] = 32'hDEAD_BEEF;

        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #2;
        chk("init_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("init_wb_data", wb_data_o, 32'h0);
        chk("init_wb_rd", 32'(wb_rd_o), 32'h0);
        chk("init_req", 32'(data_req_o), 32'h0);
        chk("init_be", 32'(data_be_o), 32'h0);
        chk("init_addr", data_addr_o, 32'h0);
        chk("init_stall", 32'(stall_o), 32'h0);
        chk("init_err", 32'(err_o), 32'h0);
        run = 1'b1;

        //        mr mw f3     addr          sdata         rd  rw g  r  err be       lit
        issue(mk(0, 0, 3'd0, 32'h0000_1234, 32'h0,         5,  1, 0, 0, 0, 4'b0000, 1, 32'h0000_1234));
        issue(mk(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 1,  0, 2, 0, 0, 4'b1000, 0, 32'h0));
        issue(mk(1, 0, 3'd0, 32'h0000_0202, 32'h0,         6,  1, 0, 1, 0, 4'b0100, 1, 32'hFFFF_FF80));
        issue(mk(1, 0, 3'd4, 32'h0000_0202, 32'h0,         6,  1, 0, 1, 0, 4'b0100, 1, 32'h0000_0080));
        issue(mk(1, 0, 3'd1, 32'h0000_0301, 32'h0,         3,  1, 0, 1, 1, 4'b0000, 0, 32'h0));
        issue(mk(0, 0, 3'd0, 32'h0000_0055, 32'h0,         7,  0, 0, 0, 0, 4'b0000, 1, 32'h0000_0055));
        issue(mk(1, 0, 3'd2, 32'h0000_0400, 32'h0,         8,  1, 1, 2, 0, 4'b1111, 1, 32'hDEAD_BEEF));
        issue(mk(0, 0, 3'd0, 32'h0000_0007, 32'h0,         9,  1, 0, 0, 0, 4'b0000, 1, 32'h0000_0007));
        issue(mk(0, 1, 3'd1, 32'h0000_0102, 32'h1234_5678, 0,  0, 0, 0, 0, 4'b1100, 0, 32'h0));
        issue(mk(1, 0, 3'd2, 32'h0000_0100, 32'h0,         10, 1, 0, 1, 0, 4'b1111, 1, 32'h5678_0000));
        issue(mk(0, 1, 3'd2, 32'h0000_0104, 32'h8001_FFFE, 0,  0, 1, 0, 0, 4'b1111, 0, 32'h0));
        issue(mk(1, 0, 3'd1, 32'h0000_0106, 32'h0,         11, 1, 0, 1, 0, 4'b1100, 1, 32'hFFFF_8001));
        issue(mk(1, 0, 3'd5, 32'h0000_0104, 32'h0,         12, 1, 0, 2, 0, 4'b0011, 1, 32'h0000_FFFE));
        issue(mk(1, 0, 3'd0, 32'h0000_0107, 32'h0,         13, 1, 0, 1, 0, 4'b1000, 1, 32'hFFFF_FF80));
        issue(mk(0, 1, 3'd2, 32'h0000_0102, 32'h0,         0,  0, 0, 0, 1, 4'b0000, 0, 32'h0));
        issue(mk(0, 1, 3'd3, 32'h0000_0100, 32'h0,         0,  0, 0, 0, 1, 4'b0000, 0, 32'h0));
        issue(mk(1, 1, 3'd2, 32'h0000_0100, 32'h0,         14, 1, 0, 0, 1, 4'b0000, 0, 32'h0));
        issue(mk(1, 0, 3'd6, 32'h0000_0100, 32'h0,         15, 1, 0, 0, 1, 4'b0000, 0, 32'h0));
        issue(mk(0, 0, 3'd0, 32'h0000_00C3, 32'h0,         16, 1, 0, 0, 0, 4'b0000, 1, 32'h0000_00C3));

        // Load left in WAIT when reset hits; its late rvalid must vanish
        issue(mk(1, 0, 3'd2, 32'h0000_0400, 32'h0,         17, 1, 0, 3, 0, 4'b1111, 1, 32'hDEAD_BEEF));
        idle();
        do_reset();
        repeat (4) @(negedge clk_i);
        issue(mk(0, 0, 3'd0, 32'h0000_00A5, 32'h0,         18, 1, 0, 0, 0, 4'b0000, 1, 32'h0000_00A5));
        idle();
        repeat (6) @(negedge clk_i);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("no_pending_rvalid", 32'(pend_rv), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
